// File: rtl/iir_sched.sv
`default_nettype none
// ============================================================================
//  Module   : iir_sched
//  Purpose  : Time-multiplexed first-order recursive filter controller.
//             One datapath computing y <- x + y/2 + y/4 is shared among
//             N = 2**CW sample channels. A round-robin arbiter grants one
//             requesting channel per clock. Stage 1 captures the granted
//             sample. Stage 2 performs a read-modify-write of that
//             channel's feedback state and registers the result.
//  Ports    : clk     - rising-edge clock
//             reset   - asynchronous active-high reset, clears all state
//             req     - per-channel request, sample held until ack
//             x_bus   - packed samples, channel i at [(i+1)*(W+1)-1 : i*(W+1)]
//             clr     - synchronous clear of channel states and pipeline
//             ack     - combinational one-hot grant
//             y_out   - registered filter result (two's complement)
//             ch_out  - channel index of y_out
//             y_valid - y_out/ch_out valid this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module iir_sched #(
  parameter int W  = 14,
  parameter int CW = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [(1<<CW)-1:0]           req,
  input  logic [(1<<CW)*(W+1)-1:0]     x_bus,
  input  logic                         clr,
  output logic [(1<<CW)-1:0]           ack,
  output logic [W:0]                   y_out,
  output logic [CW-1:0]                ch_out,
  output logic                         y_valid
);

  localparam int N  = 1 << CW;
  localparam int SW = W + 1;

  // Per-channel view of the packed sample bus
  logic signed [W:0] x_ch [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign x_ch[gi] = x_bus[gi*SW +: SW];
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [CW-1:0]     ptr_q,     ptr_d;
  logic signed [W:0] x_r_q,     x_r_d;
  logic [CW-1:0]     ch_r_q,    ch_r_d;
  logic              v1_q,      v1_d;
  logic signed [W:0] state_q [N];
  logic signed [W:0] state_d [N];
  logic signed [W:0] y_out_q,   y_out_d;
  logic [CW-1:0]     ch_out_q,  ch_out_d;
  logic              y_valid_q, y_valid_d;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first requester at or after ptr, wrapping mod N
  // --------------------------------------------------------------------------
  logic [CW-1:0] scan_idx;
  logic [CW-1:0] grant_idx;
  logic          grant_found;
  logic          grant;

  always_comb begin
    scan_idx    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      scan_idx = ptr_q + CW'(i);
      if (!grant_found && req[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // No grant while clearing; ack is also forced low during reset so that
  // requesters never see a handshake that the capture flops cannot honour.
  assign grant = grant_found & ~clr & ~reset;
  assign ack   = grant ? (N'(1) << grant_idx) : '0;

  // --------------------------------------------------------------------------
  // Stage 2 datapath: arithmetic shifts floor toward -inf, sum wraps
  // --------------------------------------------------------------------------
  logic signed [W:0] s_rd;
  logic signed [W:0] y_new;
  logic              wr_en;

  assign s_rd  = state_q[ch_r_q];
  assign y_new = x_r_q + (s_rd >>> 1) + (s_rd >>> 2);
  assign wr_en = v1_q & ~clr;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    ptr_d     = ptr_q;
    x_r_d     = x_r_q;
    ch_r_d    = ch_r_q;
    v1_d      = grant;
    y_out_d   = y_out_q;
    ch_out_d  = ch_out_q;
    y_valid_d = wr_en;

    if (clr) begin
      ptr_d = '0;
    end else if (grant) begin
      ptr_d  = grant_idx + CW'(1);
      x_r_d  = x_ch[grant_idx];
      ch_r_d = grant_idx;
    end

    if (wr_en) begin
      y_out_d  = y_new;
      ch_out_d = ch_r_q;
    end
  end

  // Clear beats a simultaneous stage-2 write to the same entry
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      if (clr) begin
        state_d[i] = '0;
      end else if (v1_q && (ch_r_q == CW'(i))) begin
        state_d[i] = y_new;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      x_r_q     <= '0;
      ch_r_q    <= '0;
      v1_q      <= 1'b0;
      y_out_q   <= '0;
      ch_out_q  <= '0;
      y_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      x_r_q     <= x_r_d;
      ch_r_q    <= ch_r_d;
      v1_q      <= v1_d;
      y_out_q   <= y_out_d;
      ch_out_q  <= ch_out_d;
      y_valid_q <= y_valid_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign y_out   = y_out_q;
  assign ch_out  = ch_out_q;
  assign y_valid = y_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iir_sched
//  Purpose  : Directed self-checking bench for iir_sched (W=14, CW=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iir_sched;

  localparam int W  = 14;
  localparam int CW = 2;
  localparam int N  = 4;
  localparam int SW = W + 1;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*SW-1:0]   x_bus;
  logic              clr;
  logic [N-1:0]      ack;
  logic [W:0]        y_out;
  logic [CW-1:0]     ch_out;
  logic              y_valid;

  int checks = 0;
  int errors = 0;

  iir_sched #(.W(W), .CW(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .x_bus   (x_bus),
    .clr     (clr),
    .ack     (ack),
    .y_out   (y_out),
    .ch_out  (ch_out),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int ch, input int val);
    logic [31:0] v;
    v = val;
    x_bus[ch*SW +: SW] = v[SW-1:0];
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int y, input int ch);
    chk({tag, ".valid"}, y_valid, 1);
    chk({tag, ".y"}, $signed(y_out), y);
    chk({tag, ".ch"}, ch_out, ch);
  endtask

  int ack_rr   [6] = '{2, 4, 8, 1, 2, 4};
  int y_rr     [6] = '{100, 200, 300, 400, 175, 350};
  int ch_rr    [6] = '{0, 1, 2, 3, 0, 1};
  int ack_alt  [4] = '{8, 2, 8, 2};
  int y_alt    [4] = '{16383, 1000, -4099, 1750};
  int ch_alt   [4] = '{1, 3, 1, 3};
  int y_step   [4] = '{1000, 1750, 2312, 2734};

  initial begin
    reset = 1'b1;
    req   = '0;
    x_bus = '0;
    clr   = 1'b0;
    #12;
    chk("rst.ack", ack, 0);
    chk("rst.y", $signed(y_out), 0);
    chk("rst.ch", ch_out, 0);
    chk("rst.valid", y_valid, 0);
    reset = 1'b0;
    #4;

    // ---- Positive step on channel 0 ----
    set_x(0, 1000);
    req = 4'b0001;
    #1;
    chk("step.ack0", ack, 1);
    tick();
    chk("step.lat_valid", y_valid, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req = 4'b0000;
      tick();
      chk_out($sformatf("step%0d", k), y_step[k], 0);
    end
    tick();
    chk("step.idle_valid", y_valid, 0);
    chk("step.hold_y", $signed(y_out), 2734);

    // ---- Negative step on channel 2 (ptr=1 scans 1,2) ----
    set_x(2, -1000);
    req = 4'b0100;
    #1;
    chk("neg.ack", ack, 4);
    tick();
    tick();
    chk_out("neg0", -1000, 2);
    tick();
    chk_out("neg1", -1750, 2);
    req = 4'b0000;
    tick();
    chk_out("neg2", -2313, 2);
    tick();
    chk("neg.idle_valid", y_valid, 0);

    // ---- Round robin with all channels requesting ----
    clr = 1'b1;
    tick();
    clr = 1'b0;
    set_x(0, 100);
    set_x(1, 200);
    set_x(2, 300);
    set_x(3, 400);
    req = 4'b1111;
    #1;
    chk("rr.ack_init", ack, 1);
    for (int t = 1; t <= 6; t++) begin
      tick();
      chk($sformatf("rr.ack%0d", t), ack, ack_rr[t-1]);
      if (t >= 2) chk_out($sformatf("rr%0d", t), y_rr[t-2], ch_rr[t-2]);
    end
    req = 4'b0000;
    tick();
    chk_out("rr7", y_rr[5], ch_rr[5]);

    // ---- Alternate channels 1 and 3, with overflow on channel 1 ----
    clr = 1'b1;
    tick();
    clr = 1'b0;
    set_x(1, 16383);
    set_x(3, 1000);
    req = 4'b1010;
    #1;
    chk("alt.ack_init", ack, 2);
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk($sformatf("alt.ack%0d", t), ack, ack_alt[t-1]);
      if (t >= 2) chk_out($sformatf("alt%0d", t), y_alt[t-2], ch_alt[t-2]);
    end
    req = 4'b0000;
    tick();
    chk_out("alt5", y_alt[3], ch_alt[3]);

    // ---- clr coinciding with a stage-2 write on channel 3 ----
    req = 4'b1000;
    #1;
    chk("clr.ack_pre", ack, 8);
    tick();
    clr = 1'b1;
    #1;
    chk("clr.ack_blocked", ack, 0);
    tick();
    chk("clr.valid", y_valid, 0);
    clr = 1'b0;
    #1;
    chk("clr.ack_post", ack, 8);
    tick();
    tick();
    chk_out("clr.restart", 1000, 3);

    // ---- Async reset between edges ----
    set_x(2, 300);
    req = 4'b1100;
    tick();
    tick();
    chk("ar.valid_before", y_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.ack", ack, 0);
    chk("ar.y", $signed(y_out), 0);
    chk("ar.ch", ch_out, 0);
    chk("ar.valid", y_valid, 0);
    #1;
    reset = 1'b0;
    #1;
    chk("ar.first_grant", ack, 4);
    tick();
    tick();
    chk_out("ar.fresh", 300, 2);
    req = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
